// File: rtl/nibble_writeback_if.sv
// Bundle of the nibble stream, word-control and register-file write signals
// between the serial ALU loop and the writeback block.
interface nibble_writeback_if #(
    parameter int NIBBLES    = 8,
    parameter int REG_ADDR_W = 5
);
    logic                    start;
    logic [REG_ADDR_W-1:0]   rd;
    logic                    abort;
    logic                    nib_valid;
    logic [3:0]              nib;
    logic                    carry_in;
    logic                    nib_ready;
    logic                    busy;
    logic                    wr_en;
    logic [REG_ADDR_W-1:0]   wr_addr;
    logic [4*NIBBLES-1:0]    wr_data;
    logic                    carry_flag;
    logic                    done;

    modport slave (
        input  start, rd, abort, nib_valid, nib, carry_in,
        output nib_ready, busy, wr_en, wr_addr, wr_data, carry_flag, done
    );

    modport master (
        output start, rd, abort, nib_valid, nib, carry_in,
        input  nib_ready, busy, wr_en, wr_addr, wr_data, carry_flag, done
    );
endinterface

// File: rtl/nibble_writeback.sv
// Collects LSB-first ALU result nibbles into a word and presents a single-cycle
// register-file write, suppressing the strobe for x0 and capturing the final carry.
module nibble_writeback #(
    parameter int NIBBLES    = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    nibble_writeback_if.slave bus
);

    localparam int WORD_W = 4 * NIBBLES;
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [WORD_W-1:0]     acc_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0]     wr_data_q;
    logic                  carry_q;

    logic                  nib_ready_c;
    logic                  busy_c;
    logic                  wr_en_c;
    logic                  done_c;
    logic                  take_start;
    logic                  accept;
    logic                  idx_last;
    logic [WORD_W-1:0]     acc_next;

    function automatic logic [WORD_W-1:0] insert_nibble(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  pos,
        input logic [3:0]        value
    );
        logic [WORD_W-1:0] res;
        res = word;
        for (int i = 0; i < NIBBLES; i++) begin
            if (pos == IDX_W'(i)) begin
                res[i*4 +: 4] = value;
            end
        end
        return res;
    endfunction

    // abort suppresses both a pending start and a coincident accept, so an
    // aborted last nibble never reaches the write or the carry flag.
    assign take_start = (state_q == S_IDLE) && bus.start && !bus.abort;
    assign accept     = bus.nib_valid && nib_ready_c && !bus.abort;
    assign idx_last   = (idx_q == IDX_W'(NIBBLES - 1));
    assign acc_next   = insert_nibble(acc_q, idx_q, bus.nib);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nib_ready_c = 1'b0;
        busy_c      = 1'b0;
        wr_en_c     = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take_start) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                nib_ready_c = 1'b1;
                busy_c      = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (accept && idx_last) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                wr_en_c = (rd_q != '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word assembly; the write registers load on the final accept so they are
    // valid throughout WRITE and then hold while the next word is collected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            acc_q     <= '0;
            rd_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            carry_q   <= 1'b0;
        end else if (take_start) begin
            idx_q <= '0;
            acc_q <= '0;
            rd_q  <= bus.rd;
        end else if (accept) begin
            acc_q <= acc_next;
            if (idx_last) begin
                idx_q     <= '0;
                wr_data_q <= acc_next;
                wr_addr_q <= rd_q;
                carry_q   <= bus.carry_in;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.nib_ready  = nib_ready_c;
    assign bus.busy       = busy_c;
    assign bus.wr_en      = wr_en_c;
    assign bus.done       = done_c;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.carry_flag = carry_q;

    a_wr_en_single: assert property (@(posedge clk) disable iff (reset) wr_en_c |=> !wr_en_c);
    a_done_single:  assert property (@(posedge clk) disable iff (reset) done_c |=> !done_c);

endmodule

// File: tb/tb_nibble_writeback.sv
// Directed bench for nibble_writeback: word assembly, x0 suppression, stalls,
// abort, asynchronous reset and strobe behaviour.
module tb_nibble_writeback;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    int   wr_count;
    int   done_count;
    int   wr_zero_count;
    int   wr_run;
    int   done_run;
    int   max_wr_run;
    int   max_done_run;
    logic [4:0]  last_wr_addr;
    logic [31:0] last_wr_data;

    nibble_writeback_if #(.NIBBLES(8), .REG_ADDR_W(5)) bus ();

    nibble_writeback #(.NIBBLES(8), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (reset) begin
            wr_run   = 0;
            done_run = 0;
        end else begin
            if (bus.wr_en === 1'b1) begin
                wr_count++;
                wr_run++;
                last_wr_addr = bus.wr_addr;
                last_wr_data = bus.wr_data;
                if (bus.wr_addr == 5'd0) wr_zero_count++;
            end else begin
                wr_run = 0;
            end
            if (bus.done === 1'b1) begin
                done_count++;
                done_run++;
            end else begin
                done_run = 0;
            end
            if (wr_run > max_wr_run) max_wr_run = wr_run;
            if (done_run > max_done_run) max_done_run = done_run;
        end
    end

    task automatic begin_word(input logic [4:0] r);
        bus.start = 1'b1;
        bus.rd    = r;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rd    = ~r;
    endtask

    task automatic put_nib(input logic [3:0] n, input logic c);
        bus.nib_valid = 1'b1;
        bus.nib       = n;
        bus.carry_in  = c;
        @(negedge clk);
        bus.nib_valid = 1'b0;
        bus.carry_in  = 1'b0;
    endtask

    // Ends at the negedge of the WRITE cycle.
    task automatic send_word(input logic [4:0] r, input logic [31:0] w, input logic c);
        begin_word(r);
        for (int i = 0; i < 8; i++) put_nib(w[i*4 +: 4], (i == 7) ? c : 1'b0);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (bus.nib_ready !== 1'b0) begin bad++; $display("FAIL reset_nib_ready got=%0h exp=0", bus.nib_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.wr_en !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%0h%0h exp=00", bus.wr_en, bus.done); end
        total++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_bus got=%0h/%0h exp=0/0", bus.wr_addr, bus.wr_data); end
        total++; if (bus.carry_flag !== 1'b0) begin bad++; $display("FAIL reset_carry got=%0h exp=0", bus.carry_flag); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int base;
        base = wr_count;
        begin_word(5'd5);
        total++; if (bus.nib_ready !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_collect got=%0h%0h exp=11", bus.nib_ready, bus.busy); end
        for (int i = 0; i < 7; i++) put_nib(4'hF, 1'b0);
        total++; if (bus.wr_en !== 1'b0 || bus.nib_ready !== 1'b1) begin bad++; $display("FAIL basic_early got=%0h%0h exp=01", bus.wr_en, bus.nib_ready); end
        put_nib(4'hE, 1'b1);
        total++; if (bus.wr_en !== 1'b1 || bus.done !== 1'b1) begin bad++; $display("FAIL basic_strobes got=%0h%0h exp=11", bus.wr_en, bus.done); end
        total++; if (bus.wr_addr !== 5'd5) begin bad++; $display("FAIL basic_addr got=%0d exp=5", bus.wr_addr); end
        total++; if (bus.wr_data !== 32'hEFFFFFFF) begin bad++; $display("FAIL basic_data got=%h exp=efffffff", bus.wr_data); end
        total++; if (bus.carry_flag !== 1'b1) begin bad++; $display("FAIL basic_carry got=%0h exp=1", bus.carry_flag); end
        total++; if (bus.nib_ready !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_write_state got=%0h%0h exp=01", bus.nib_ready, bus.busy); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL basic_idle got=%0h%0h%0h exp=000", bus.busy, bus.wr_en, bus.done); end
        total++; if (bus.wr_data !== 32'hEFFFFFFF || bus.carry_flag !== 1'b1) begin bad++; $display("FAIL basic_hold got=%h/%0h exp=efffffff/1", bus.wr_data, bus.carry_flag); end
        total++; if (wr_count - base !== 1) begin bad++; $display("FAIL basic_wr_count got=%0d exp=1", wr_count - base); end
    endtask

    task automatic test_rd_zero;
        int base;
        int dbase;
        base  = wr_count;
        dbase = done_count;
        send_word(5'd0, 32'h87654321, 1'b0);
        total++; if (bus.done !== 1'b1 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL rd0_strobes got=%0h%0h exp=10", bus.done, bus.wr_en); end
        total++; if (bus.wr_data !== 32'h87654321 || bus.wr_addr !== 5'd0) begin bad++; $display("FAIL rd0_bus got=%h/%0d exp=87654321/0", bus.wr_data, bus.wr_addr); end
        total++; if (bus.carry_flag !== 1'b0) begin bad++; $display("FAIL rd0_carry got=%0h exp=0", bus.carry_flag); end
        @(negedge clk);
        total++; if (wr_count - base !== 0 || done_count - dbase !== 1) begin bad++; $display("FAIL rd0_counts got=%0d/%0d exp=0/1", wr_count - base, done_count - dbase); end
    endtask

    task automatic test_stalls;
        int base;
        base = wr_count;
        begin_word(5'd3);
        for (int i = 0; i < 8; i++) begin
            put_nib(4'hA, 1'b0);
            if (i == 1 || i == 5) begin
                bus.nib = 4'h5;
                repeat ((i == 1) ? 3 : 1) begin
                    total++; if (bus.nib_ready !== 1'b1 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL stall_hold got=%0h%0h exp=10", bus.nib_ready, bus.wr_en); end
                    @(negedge clk);
                end
            end
        end
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hAAAAAAAA) begin bad++; $display("FAIL stall_write got=%0h/%0d/%h exp=1/3/aaaaaaaa", bus.wr_en, bus.wr_addr, bus.wr_data); end
        @(negedge clk);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL stall_one_cycle got=%0h exp=0", bus.wr_en); end
        total++; if (wr_count - base !== 1) begin bad++; $display("FAIL stall_wr_count got=%0d exp=1", wr_count - base); end
    endtask

    task automatic test_abort;
        int base;
        base = wr_count;
        begin_word(5'd7);
        for (int i = 0; i < 4; i++) put_nib(4'hC, 1'b0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.nib_ready !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0h%0h exp=00", bus.busy, bus.nib_ready); end
        @(negedge clk);
        send_word(5'd9, 32'h33333333, 1'b1);
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'h33333333) begin bad++; $display("FAIL abort_next got=%0h/%0d/%h exp=1/9/33333333", bus.wr_en, bus.wr_addr, bus.wr_data); end
        @(negedge clk);
        total++; if (wr_count - base !== 1 || last_wr_addr !== 5'd9) begin bad++; $display("FAIL abort_wr_count got=%0d/%0d exp=1/9", wr_count - base, last_wr_addr); end
    endtask

    task automatic test_async_reset;
        int base;
        int dbase;
        base = wr_count;
        begin_word(5'd6);
        for (int i = 0; i < 5; i++) put_nib(4'h9, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.nib_ready !== 1'b0) begin bad++; $display("FAIL areset_ctrl got=%0h%0h exp=00", bus.busy, bus.nib_ready); end
        total++; if (bus.wr_data !== 32'd0 || bus.wr_addr !== 5'd0 || bus.carry_flag !== 1'b0) begin bad++; $display("FAIL areset_data got=%h/%0d/%0h exp=0/0/0", bus.wr_data, bus.wr_addr, bus.carry_flag); end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (wr_count - base !== 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL areset_no_write got=%0d/%0h exp=0/0", wr_count - base, bus.busy); end
        dbase = done_count;
        begin_word(5'd4);
        for (int i = 0; i < 7; i++) put_nib(4'h6, 1'b0);
        bus.abort = 1'b1;
        put_nib(4'h6, 1'b1);
        bus.abort = 1'b0;
        total++; if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_last got=%0h%0h%0h exp=000", bus.wr_en, bus.done, bus.busy); end
        total++; if (bus.carry_flag !== 1'b0 || bus.wr_data !== 32'd0) begin bad++; $display("FAIL abort_last_hold got=%0h/%h exp=0/0", bus.carry_flag, bus.wr_data); end
        repeat (3) @(negedge clk);
        total++; if (done_count - dbase !== 0 || wr_count - base !== 0) begin bad++; $display("FAIL abort_last_counts got=%0d/%0d exp=0/0", done_count - dbase, wr_count - base); end
    endtask

    task automatic test_ignored_controls;
        begin_word(5'd12);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin bus.start = 1'b1; bus.rd = 5'd13; end
            put_nib(4'(i), 1'b0);
            bus.start = 1'b0;
        end
        bus.abort     = 1'b1;
        bus.start     = 1'b1;
        bus.rd        = 5'd11;
        bus.nib_valid = 1'b1;
        bus.nib       = 4'hB;
        #1;
        total++; if (bus.wr_en !== 1'b1 || bus.done !== 1'b1) begin bad++; $display("FAIL write_abort got=%0h%0h exp=11", bus.wr_en, bus.done); end
        total++; if (bus.wr_addr !== 5'd12 || bus.wr_data !== 32'h76543210) begin bad++; $display("FAIL ignore_start got=%0d/%h exp=12/76543210", bus.wr_addr, bus.wr_data); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.nib_ready !== 1'b0) begin bad++; $display("FAIL start_in_write got=%0h%0h exp=00", bus.busy, bus.nib_ready); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_beats_start got=%0h exp=0", bus.busy); end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.nib_ready !== 1'b0 || bus.wr_data !== 32'h76543210 || bus.busy !== 1'b0) begin bad++; $display("FAIL idle_nib_valid got=%0h/%h/%0h exp=0/76543210/0", bus.nib_ready, bus.wr_data, bus.busy); end
        bus.nib_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        send_word(5'd20, 32'h23456789, 1'b0);
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd20 || bus.wr_data !== 32'h23456789) begin bad++; $display("FAIL b2b_first got=%0h/%0d/%h exp=1/20/23456789", bus.wr_en, bus.wr_addr, bus.wr_data); end
        @(negedge clk);
        send_word(5'd21, 32'hFEDCBA98, 1'b1);
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd21 || bus.wr_data !== 32'hFEDCBA98) begin bad++; $display("FAIL b2b_second got=%0h/%0d/%h exp=1/21/fedcba98", bus.wr_en, bus.wr_addr, bus.wr_data); end
        total++; if (bus.carry_flag !== 1'b1) begin bad++; $display("FAIL b2b_carry got=%0h exp=1", bus.carry_flag); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_totals;
        total++; if (wr_count !== 6 || done_count !== 7) begin bad++; $display("FAIL totals got=%0d/%0d exp=6/7", wr_count, done_count); end
        total++; if (wr_zero_count !== 0) begin bad++; $display("FAIL x0_writes got=%0d exp=0", wr_zero_count); end
        total++; if (max_wr_run !== 1 || max_done_run !== 1) begin bad++; $display("FAIL strobe_runs got=%0d/%0d exp=1/1", max_wr_run, max_done_run); end
        total++; if (last_wr_addr !== 5'd21 || last_wr_data !== 32'hFEDCBA98) begin bad++; $display("FAIL last_write got=%0d/%h exp=21/fedcba98", last_wr_addr, last_wr_data); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        wr_count      = 0;
        done_count    = 0;
        wr_zero_count = 0;
        wr_run        = 0;
        done_run      = 0;
        max_wr_run    = 0;
        max_done_run  = 0;
        last_wr_addr  = '0;
        last_wr_data  = '0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.rd        = '0;
        bus.abort     = 1'b0;
        bus.nib_valid = 1'b0;
        bus.nib       = '0;
        bus.carry_in  = 1'b0;

        test_reset;
        test_basic;
        test_rd_zero;
        test_stalls;
        test_abort;
        test_async_reset;
        test_ignored_controls;
        test_back_to_back;
        test_totals;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
